// File: rtl/alu_mul_shift_unit_if.sv
// Operand/opcode bus into the ALU/multiplier/shifter unit and its registered result bus.
// Latency: none (wiring only); results appear one clk edge after valid_in.
// Backpressure: none; the master may present a new operation every cycle.
interface alu_mul_shift_unit_if #(
   parameter int WIDTH = 8
) ();
   logic                     valid_in;
   logic [WIDTH-1:0]         a;
   logic [WIDTH-1:0]         b;
   logic [3:0]               opcode;
   logic [$clog2(WIDTH)-1:0] shift;
   logic [2*WIDTH-1:0]       result;
   logic                     carry;
   logic                     valid_out;

   modport master (
      output valid_in, a, b, opcode, shift,
      input  result, carry, valid_out
   );

   modport slave (
      input  valid_in, a, b, opcode, shift,
      output result, carry, valid_out
   );
endinterface

// File: rtl/alu_mul_shift_unit.sv
// Execute-stage unit: 8-bit ALU, unsigned array multiplier and left barrel shifter.
// Latency: one cycle; operands captured on valid_in are visible with valid_out after the edge.
// Backpressure: none; accepts one operation per cycle, outputs hold when valid_in is low.
module alu_mul_shift_unit #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   alu_mul_shift_unit_if.slave bus
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b0111;

   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   shl_s1;
   logic [WIDTH-1:0]   shl_s2;
   logic [WIDTH-1:0]   shl_out;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [2*WIDTH-1:0] nxt_result;
   logic               nxt_carry;
   logic [SW-1:0]      shamt;

   assign shamt = bus.shift;

   // Array multiplier: each row ANDs a with one bit of b and ripple-adds it into the running sum.
   always_comb begin : mul_array
      logic cy;
      logic pp;
      logic s;
      cy       = 1'b0;
      pp       = 1'b0;
      s        = 1'b0;
      mul_prod = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cy = 1'b0;
         for (int j = 0; j < WIDTH; j++) begin
            pp              = bus.a[j] & bus.b[i];
            s               = mul_prod[i+j] ^ pp ^ cy;
            cy              = (mul_prod[i+j] & pp) | (cy & (mul_prod[i+j] ^ pp));
            mul_prod[i+j]   = s;
         end
         // The running sum after i rows is below 2^(WIDTH+i), so this bit is still free.
         mul_prod[i+WIDTH] = cy;
      end
   end

   // Barrel shifter: shift by 1, 2 and 4 in cascaded stages, zero fill from the right.
   always_comb begin
      shl_s1  = shamt[0] ? {bus.a[WIDTH-2:0], 1'b0}   : bus.a;
      shl_s2  = shamt[1] ? {shl_s1[WIDTH-3:0], 2'b00} : shl_s1;
      shl_out = shamt[2] ? {shl_s2[WIDTH-5:0], 4'h0}  : shl_s2;
   end

   assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_diff = {1'b0, bus.a} - {1'b0, bus.b};

   // Opcode select; the upper result byte stays zero except for the product.
   always_comb begin
      nxt_result = '0;
      nxt_carry  = 1'b0;
      case (bus.opcode)
         OP_ADD: begin
            nxt_result = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
            nxt_carry  = add_sum[WIDTH];
         end
         OP_SUB: begin
            nxt_result = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
            // The wrap into the extra bit is exactly the a<b borrow.
            nxt_carry  = sub_diff[WIDTH];
         end
         OP_AND:  nxt_result = {{WIDTH{1'b0}}, bus.a & bus.b};
         OP_OR:   nxt_result = {{WIDTH{1'b0}}, bus.a | bus.b};
         OP_XOR:  nxt_result = {{WIDTH{1'b0}}, bus.a ^ bus.b};
         OP_NOT:  nxt_result = {{WIDTH{1'b0}}, ~bus.a};
         OP_MUL:  nxt_result = mul_prod;
         OP_SHL:  nxt_result = {{WIDTH{1'b0}}, shl_out};
         default: begin
            nxt_result = '0;
            nxt_carry  = 1'b0;
         end
      endcase
   end

   // Result register: capture on valid_in, otherwise hold; valid_out flags a fresh capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.result    <= '0;
         bus.carry     <= 1'b0;
         bus.valid_out <= 1'b0;
      end else begin
         bus.valid_out <= bus.valid_in;
         if (bus.valid_in) begin
            bus.result <= nxt_result;
            bus.carry  <= nxt_carry;
         end
      end
   end

endmodule

// File: tb/tb_alu_mul_shift_unit.sv
// Scoreboard bench for alu_mul_shift_unit: directed plan vectors plus random traffic.
// Latency: expects each captured operation one edge later.
// Backpressure: none; the bench may issue an operation every cycle.
module tb_alu_mul_shift_unit;

   logic clk;
   logic rst;

   alu_mul_shift_unit_if #(.WIDTH(8)) bus ();

   alu_mul_shift_unit #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   logic [16:0] exp_q[$];
   logic [15:0] held_res = 16'd0;
   logic        held_car = 1'b0;
   logic        mon_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference behaviour from plain integer arithmetic; returns {carry, result}.
   function automatic logic [16:0] ref_model(input int a, input int b, input int op, input int sh);
      int   r;
      logic c;
      r = 0;
      c = 1'b0;
      case (op)
         0: begin r = (a + b) % 256;       c = (a + b) > 255; end
         1: begin r = (a - b + 256) % 256; c = a < b;         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 255 - a;
         6: r = a * b;
         7: r = (a * (1 << sh)) % 256;
         default: r = 0;
      endcase
      return {c, r[15:0]};
   endfunction

   task automatic issue(input logic v, input int a, input int b, input int op, input int sh);
      @(negedge clk);
      bus.valid_in = v;
      bus.a        = a[7:0];
      bus.b        = b[7:0];
      bus.opcode   = op[3:0];
      bus.shift    = sh[2:0];
      if (v) exp_q.push_back(ref_model(a, b, op, sh));
   endtask

   // Monitor: pops an expectation whenever the unit flags a result, else checks the hold.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (bus.valid_out === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_valid_out", 32'(bus.valid_out), 32'd0);
               end else begin
                  logic [16:0] e;
                  e = exp_q.pop_front();
                  held_res = e[15:0];
                  held_car = e[16];
                  check("result", 32'(bus.result), 32'(e[15:0]));
                  check("carry",  32'(bus.carry),  32'(e[16]));
               end
            end else begin
               check("hold_result", 32'(bus.result), 32'(held_res));
               check("hold_carry",  32'(bus.carry),  32'(held_car));
            end
         end
      end
   end

   initial begin
      int a, b, op, sh, guard;
      logic v;
      bus.valid_in = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.opcode   = '0;
      bus.shift    = '0;
      rst          = 1'b0;

      // Reset asserted between edges must clear outputs at once.
      #2 rst = 1'b1;
      #1;
      check("reset_result",    32'(bus.result),    32'd0);
      check("reset_carry",     32'(bus.carry),     32'd0);
      check("reset_valid_out", 32'(bus.valid_out), 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      issue(1'b0, 0, 0, 0, 0);

      // ALU sweep a=25, b=10.
      for (int k = 0; k < 6; k++) issue(1'b1, 25, 10, k, 0);
      // Carry and borrow corners.
      issue(1'b1, 200, 100, 0, 0);
      issue(1'b1, 10, 25, 1, 0);
      issue(1'b1, 25, 25, 1, 0);
      // Multiplier corners.
      issue(1'b1, 12, 10, 6, 0);
      issue(1'b1, 255, 255, 6, 0);
      issue(1'b1, 0, 200, 6, 0);
      // Shifter: 0xB3 by 3, 0 and 7.
      issue(1'b1, 8'hB3, 0, 7, 3);
      issue(1'b1, 8'hB3, 0, 7, 0);
      issue(1'b1, 8'hB3, 0, 7, 7);
      // Hold with changing operands, then a reserved opcode.
      issue(1'b0, 77, 99, 6, 2);
      issue(1'b0, 13, 200, 0, 5);
      issue(1'b1, 99, 44, 15, 1);
      issue(1'b1, 99, 44, 0, 1);

      // Random traffic, biased toward defined opcodes.
      for (int k = 0; k < 400; k++) begin
         v  = ($urandom_range(0, 3) != 0);
         a  = int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         op = int'($urandom_range(0, 9));
         if (op > 7) op = int'($urandom_range(8, 15));
         sh = int'($urandom_range(0, 7));
         issue(v, a, b, op, sh);
      end
      issue(1'b1, 1, 1, 0, 0);
      issue(1'b0, 0, 0, 0, 0);

      // Drain the scoreboard within a bounded number of cycles.
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-operation discards the pending capture.
      @(negedge clk);
      mon_en       = 1'b0;
      bus.valid_in = 1'b1;
      bus.a        = 8'd100;
      bus.b        = 8'd50;
      bus.opcode   = 4'd6;
      #2 rst = 1'b1;
      #1;
      check("midop_reset_result",    32'(bus.result),    32'd0);
      check("midop_reset_carry",     32'(bus.carry),     32'd0);
      check("midop_reset_valid_out", 32'(bus.valid_out), 32'd0);
      @(posedge clk);
      #1;
      check("reset_blocks_capture_result", 32'(bus.result),    32'd0);
      check("reset_blocks_capture_valid",  32'(bus.valid_out), 32'd0);
      @(negedge clk);
      bus.valid_in = 1'b0;
      rst          = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_idle_result", 32'(bus.result),    32'd0);
      check("post_reset_idle_valid",  32'(bus.valid_out), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/alu_mul_shift_unit.md
Name: alu_mul_shift_unit

Overview:
Registered 8-bit datapath unit that combines three functions: a logic/arithmetic ALU, an 8x8 unsigned array multiplier and a left barrel shifter.
An opcode selects which function drives a 16-bit result register.
The unit sits in the execute stage of a small datapath and produces one result per cycle with single-cycle latency.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH and shift-amount width is log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- valid_in  input  1  operands and opcode are valid this cycle; capture them
- a  input  8  operand A (unsigned)
- b  input  8  operand B (unsigned)
- opcode  input  4  operation select
- shift  input  3  shift amount for SHL
- result  output  16  registered result
- carry  output  1  registered carry/borrow flag
- valid_out  output  1  result/carry updated on the previous edge

Behaviour:
- Reset: while rst=1, asynchronously and immediately force result=0, carry=0, valid_out=0, regardless of clk. Reset asserted mid-operation discards the pending capture.
- Latency: the combinational result is computed from a, b, opcode and shift. On the rising clk edge with valid_in=1 it is registered into result/carry, and valid_out=1 the same edge.
- With valid_in=0 on an edge: result and carry hold their values; valid_out=0.
- Opcode map. Unless stated, result[15:8]=0 and carry=0.
  - 0000 ADD: {carry,result[7:0]} = a+b (9-bit sum); carry is bit 8.
  - 0001 SUB: result[7:0] = (a-b) mod 256; carry=1 when a<b (borrow), else 0.
  - 0010 AND: a&b.
  - 0011 OR: a|b.
  - 0100 XOR: a^b.
  - 0101 NOT: ~a; b is ignored.
  - 0110 MUL: result = a*b, full 16-bit unsigned product.
  - 0111 SHL: result[7:0] = a<<shift; zero fill; bits shifted out are discarded; shift=0 passes a unchanged.
  - 1000..1111: reserved; result=0, carry=0, valid_out still follows valid_in.
- Multiplier structure: an AND-gate partial-product array (8 rows of a&b[i]) reduced by rows of ripple-carry adders. It is purely combinational, with no pipelining inside the unit. Max product 255*255 = 65025.
- Shifter structure: three cascaded mux stages conditioned on shift[0], shift[1] and shift[2] (shifts by 1, 2 and 4). Combinational.
- Width rules: all operands are unsigned. There are no sign flags or overflow flags. The result is never sign-extended.
- Back-to-back operations: a new valid_in every cycle yields a new result every cycle. There are no stalls and no backpressure.

Test Plan:
- Reset: assert rst between clock edges -> result=0, carry=0, valid_out=0 immediately. Deassert and apply valid_in=0 for one edge -> all outputs stay 0.
- ALU sweep with a=25, b=10, valid_in=1, one opcode per cycle -> after each edge: ADD 35/c0, SUB 15/c0, AND 8, OR 27, XOR 19, NOT 230, each with valid_out=1.
- Carry/borrow: ADD a=200, b=100 -> result=44, carry=1. SUB a=10, b=25 -> result=241, carry=1. SUB a=25, b=25 -> result=0, carry=0.
- MUL: a=12, b=10 -> 120. a=255, b=255 -> 65025. a=0, b=200 -> 0. carry=0 in all cases.
- SHL: a=8'b10110011 with shift=3 -> 8'b10011000. With shift=0 -> 8'b10110011. With shift=7 -> 8'b10000000. result[15:8]=0.
- Hold and reserved: valid_in=0 with changing operands -> result unchanged, valid_out=0. opcode=1111 with valid_in=1 -> result=0, carry=0, valid_out=1.
